hc85_seq_cmp: RTL

Sequencer that time-shares a single 4-bit HC_85 magnitude comparator to compare two wide words, one nibble per clock, MSB nibble first. It sits beside the HC_85 instance. It drives the comparator's nibble and cascade inputs, samples its three outputs, and returns a registered GT/LT/EQ verdict with a DONE pulse. It replaces a chain of cascaded comparator chips with one chip plus control.

---
 rtl/hc85_seq_cmp_if.sv | 33 +++
 rtl/hc85_seq_cmp.sv | 114 +++++++++++
 2 files changed

// File: rtl/hc85_seq_cmp_if.sv
// Bus between hc85_seq_cmp and its environment: operand handshake, verdict,
// and the pins of the shared HC_85 comparator.
interface hc85_seq_cmp_if #(
    parameter int NIBBLES = 4
);
    logic                   START;
    logic [4*NIBBLES-1:0]   A;
    logic [4*NIBBLES-1:0]   B;
    logic [3:0]             CA;
    logic [3:0]             CB;
    logic                   CI1;
    logic                   CI2;
    logic                   CI3;
    logic                   CQ1;
    logic                   CQ2;
    logic                   CQ3;
    logic                   BUSY;
    logic                   DONE;
    logic                   GT;
    logic                   LT;
    logic                   EQ;
    logic                   ERR;

    modport master (
        output START, A, B, CQ1, CQ2, CQ3,
        input  CA, CB, CI1, CI2, CI3, BUSY, DONE, GT, LT, EQ, ERR
    );

    modport slave (
        input  START, A, B, CQ1, CQ2, CQ3,
        output CA, CB, CI1, CI2, CI3, BUSY, DONE, GT, LT, EQ, ERR
    );
endinterface

// File: rtl/hc85_seq_cmp.sv
// Time-shares one HC_85 4-bit comparator to compare two wide words, MSB nibble first.
// Optional macro HC85_SEQ_EARLY_EXIT_EN: stop scanning at the first mismatching nibble.
module hc85_seq_cmp #(
    parameter int NIBBLES = 4
) (
    input  logic            CLK,
    input  logic            RST,
    hc85_seq_cmp_if.slave   bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]      state;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            dir_gt;
    logic            dir_lt;
    logic            gt;
    logic            lt;
    logic            eq;
    logic            err;

    logic [W-1:0]    a_shift;
    logic [W-1:0]    b_shift;
    logic            one_hot;
    logic            found;
    logic            next_gt;
    logic            next_lt;
    logic            exit_scan;

    always_comb begin
        a_shift = a_reg >> {idx, 2'b00};
        b_shift = b_reg >> {idx, 2'b00};
        one_hot = ( bus.CQ1 & ~bus.CQ2 & ~bus.CQ3) |
                  (~bus.CQ1 &  bus.CQ2 & ~bus.CQ3) |
                  (~bus.CQ1 & ~bus.CQ2 &  bus.CQ3);
        found   = dir_gt | dir_lt;
        // The first decisive nibble wins; a non-one-hot sample counts as equal.
        next_gt = found ? dir_gt : (one_hot & bus.CQ1);
        next_lt = found ? dir_lt : (one_hot & bus.CQ2);
`ifdef HC85_SEQ_EARLY_EXIT_EN
        exit_scan = (idx == '0) || next_gt || next_lt;
`else
        exit_scan = (idx == '0);
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            idx    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            dir_gt <= 1'b0;
            dir_lt <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        a_reg  <= bus.A;
                        b_reg  <= bus.B;
                        dir_gt <= 1'b0;
                        dir_lt <= 1'b0;
                        err    <= 1'b0;
                        idx    <= IDXW'(NIBBLES - 1);
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!one_hot) begin
                        err <= 1'b1;
                    end
                    dir_gt <= next_gt;
                    dir_lt <= next_lt;
                    if (exit_scan) begin
                        gt    <= next_gt;
                        lt    <= next_lt;
                        eq    <= ~(next_gt | next_lt);
                        state <= FIN;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.CA   = (state == SCAN) ? a_shift[3:0] : 4'h0;
    assign bus.CB   = (state == SCAN) ? b_shift[3:0] : 4'h0;
    assign bus.CI1  = 1'b0;
    assign bus.CI2  = 1'b0;
    assign bus.CI3  = 1'b1;
    assign bus.BUSY = (state != IDLE);
    assign bus.DONE = (state == FIN);
    assign bus.GT   = gt;
    assign bus.LT   = lt;
    assign bus.EQ   = eq;
    assign bus.ERR  = err;
endmodule
